// File: rtl/regwrite_arbiter_pkg.sv
// regwrite_arbiter_pkg: shared widths, zero-register index and buffered write request type
package regwrite_arbiter_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic valid;
    logic kill;
    logic [ADDR_W-1:0] id;
    logic [DATA_W-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/regwrite_arbiter_if.sv
// regwrite_arbiter_if: WB/MDU request, register-file write and hazard signals of the arbiter
interface regwrite_arbiter_if
  import regwrite_arbiter_pkg::*;
#(parameter int DEPTH = 2);
  localparam int CW = $clog2(DEPTH + 1);
  logic is_stalling;
  logic wb_we;
  logic [ADDR_W-1:0] wb_id;
  logic [DATA_W-1:0] wb_data;
  logic mdu_valid;
  logic [ADDR_W-1:0] mdu_id;
  logic [DATA_W-1:0] mdu_data;
  logic mdu_ready;
  logic rf_we;
  logic [ADDR_W-1:0] rf_id;
  logic [DATA_W-1:0] rf_data;
  logic [ADDR_W-1:0] rd_rs_id;
  logic [ADDR_W-1:0] rd_rt_id;
  logic hazard;
  logic [CW-1:0] count;
  modport master (
    output is_stalling, wb_we, wb_id, wb_data, mdu_valid, mdu_id, mdu_data, rd_rs_id, rd_rt_id,
    input mdu_ready, rf_we, rf_id, rf_data, hazard, count
  );
  modport slave (
    input is_stalling, wb_we, wb_id, wb_data, mdu_valid, mdu_id, mdu_data, rd_rs_id, rd_rt_id,
    output mdu_ready, rf_we, rf_id, rf_data, hazard, count
  );
endinterface

// File: rtl/regwrite_fifo.sv
// regwrite_fifo: circular buffer of pending MDU writes with id-match kill and hazard match vector
module regwrite_fifo
  import regwrite_arbiter_pkg::*;
#(parameter int DEPTH = 2) (
  input  logic sys_clk,
  input  logic rst,
  input  logic push,
  input  logic push_kill,
  input  logic [ADDR_W-1:0] push_id,
  input  logic [DATA_W-1:0] push_data,
  input  logic pop,
  input  logic kill_en,
  input  logic [ADDR_W-1:0] kill_id,
  input  logic [ADDR_W-1:0] rs_id,
  input  logic [ADDR_W-1:0] rt_id,
  output wr_req_t head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [DEPTH-1:0] hit
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  wr_req_t mem [DEPTH];
  logic [PW-1:0] hd, tl;
  assign head = mem[hd];
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    assign hit[i] = mem[i].valid && !mem[i].kill && (mem[i].id == rs_id || mem[i].id == rt_id);
  end
  // kill matching entries, then retire head and append tail; pointers wrap by width
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      hd <= '0;
      tl <= '0;
      count <= '0;
      for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
    end else begin
      for (int j = 0; j < DEPTH; j++)
        if (kill_en && mem[j].valid && mem[j].id == kill_id) mem[j].kill <= 1'b1;
      if (pop) mem[hd].valid <= 1'b0;
      if (push) mem[tl] <= '{valid: 1'b1, kill: push_kill, id: push_id, data: push_data};
      hd <= hd + PW'(pop);
      tl <= tl + PW'(push);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/regwrite_arbiter.sv
// regwrite_arbiter: shares the register-file write port between WB and the MDU
module regwrite_arbiter
  import regwrite_arbiter_pkg::*;
#(parameter int DEPTH = 2) (
  input logic sys_clk,
  input logic rst,
  regwrite_arbiter_if.slave bus
);
  wr_req_t head;
  logic [DEPTH-1:0] hit;
  logic [$clog2(DEPTH+1)-1:0] cnt;
  logic wb_req, wb_kill, mdu_acc, bypass, head_live, pop, push;
  assign bus.count = cnt;
  // WB wins, then a live buffer head, then an MDU bypass into an empty buffer
  always_comb begin
    wb_req = bus.wb_we && bus.wb_id != REG_ZERO;
    wb_kill = wb_req && !bus.is_stalling;
    bus.mdu_ready = !rst && int'(cnt) < DEPTH;
    mdu_acc = bus.mdu_valid && bus.mdu_id != REG_ZERO && bus.mdu_ready;
    bypass = mdu_acc && cnt == '0 && !wb_req && !bus.is_stalling;
    head_live = head.valid && !head.kill;
    pop = head.valid && (head.kill || (!wb_req && !bus.is_stalling));
    push = mdu_acc && !bypass;
    bus.rf_we = !rst && (wb_req || head_live || bypass);
    bus.rf_id = rst ? REG_ZERO : wb_req ? bus.wb_id : head_live ? head.id : bypass ? bus.mdu_id : REG_ZERO;
    bus.rf_data = rst ? '0 : wb_req ? bus.wb_data : head_live ? head.data : bypass ? bus.mdu_data : '0;
    bus.hazard = !rst && (|hit || (mdu_acc && (bus.mdu_id == bus.rd_rs_id || bus.mdu_id == bus.rd_rt_id)));
  end
  regwrite_fifo #(.DEPTH(DEPTH)) u_fifo (
    .sys_clk(sys_clk),
    .rst(rst),
    .push(push),
    .push_kill(wb_kill && bus.wb_id == bus.mdu_id),
    .push_id(bus.mdu_id),
    .push_data(bus.mdu_data),
    .pop(pop),
    .kill_en(wb_kill),
    .kill_id(bus.wb_id),
    .rs_id(bus.rd_rs_id),
    .rt_id(bus.rd_rt_id),
    .head(head),
    .count(cnt),
    .hit(hit)
  );
endmodule

// File: tb/tb_regwrite_arbiter.sv
// tb_regwrite_arbiter: directed vectors with hand-computed expectations for regwrite_arbiter
module tb_regwrite_arbiter;
  logic sys_clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  regwrite_arbiter_if #(.DEPTH(2)) bus();
  regwrite_arbiter #(.DEPTH(2)) dut (.sys_clk(sys_clk), .rst(rst), .bus(bus));
  always #5 sys_clk = ~sys_clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask
  task automatic wb(input logic we, input logic [4:0] id, input logic [31:0] d);
    bus.wb_we = we;
    bus.wb_id = id;
    bus.wb_data = d;
  endtask
  task automatic mdu(input logic v, input logic [4:0] id, input logic [31:0] d);
    bus.mdu_valid = v;
    bus.mdu_id = id;
    bus.mdu_data = d;
  endtask
  initial begin
    bus.is_stalling = 0;
    bus.rd_rs_id = 0;
    bus.rd_rt_id = 0;
    wb(0, 0, 0);
    mdu(0, 0, 0);
    tick();
    chk("rst_we", bus.rf_we, 0);
    chk("rst_id", bus.rf_id, 0);
    chk("rst_data", bus.rf_data, 0);
    chk("rst_rdy", bus.mdu_ready, 0);
    chk("rst_haz", bus.hazard, 0);
    chk("rst_cnt", bus.count, 0);
    rst = 0;
    #1;
    chk("rdy_after_rst", bus.mdu_ready, 1);
    mdu(1, 8, 32'h1234);
    #1;
    chk("byp_we", bus.rf_we, 1);
    chk("byp_id", bus.rf_id, 8);
    chk("byp_data", bus.rf_data, 32'h1234);
    tick();
    mdu(0, 0, 0);
    chk("byp_cnt", bus.count, 0);
    wb(1, 3, 32'h33);
    mdu(1, 5, 32'h55);
    #1;
    chk("wb_pri_id", bus.rf_id, 3);
    chk("wb_pri_data", bus.rf_data, 32'h33);
    tick();
    chk("q1_cnt", bus.count, 1);
    mdu(1, 6, 32'h66);
    tick();
    chk("q2_cnt", bus.count, 2);
    chk("full_rdy", bus.mdu_ready, 0);
    mdu(1, 7, 32'h77);
    tick();
    chk("full_hold_cnt", bus.count, 2);
    wb(0, 0, 0);
    #1;
    chk("drain_r5_id", bus.rf_id, 5);
    chk("drain_r5_data", bus.rf_data, 32'h55);
    chk("drain_full_rdy", bus.mdu_ready, 0);
    tick();
    chk("drain_cnt1", bus.count, 1);
    chk("drain_r6_id", bus.rf_id, 6);
    chk("drain_r6_data", bus.rf_data, 32'h66);
    chk("drain_rdy", bus.mdu_ready, 1);
    tick();
    mdu(0, 0, 0);
    chk("pushpop_cnt", bus.count, 1);
    chk("drain_r7_id", bus.rf_id, 7);
    tick();
    chk("drained_cnt", bus.count, 0);
    chk("drained_we", bus.rf_we, 0);
    wb(1, 1, 32'h11);
    mdu(1, 9, 32'hAA);
    tick();
    mdu(0, 0, 0);
    wb(1, 9, 32'hBB);
    #1;
    chk("stale_id", bus.rf_id, 9);
    chk("stale_data", bus.rf_data, 32'hBB);
    tick();
    wb(0, 0, 0);
    #1;
    chk("killed_cnt", bus.count, 1);
    chk("killed_we", bus.rf_we, 0);
    tick();
    chk("killed_pop", bus.count, 0);
    wb(1, 13, 32'hD0);
    mdu(1, 13, 32'hD1);
    tick();
    wb(0, 0, 0);
    mdu(0, 0, 0);
    #1;
    chk("samecyc_cnt", bus.count, 1);
    chk("samecyc_we", bus.rf_we, 0);
    tick();
    chk("samecyc_pop", bus.count, 0);
    wb(1, 1, 32'h11);
    mdu(1, 4, 32'h44);
    tick();
    wb(0, 0, 0);
    mdu(0, 0, 0);
    bus.is_stalling = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_we", bus.rf_we, 1);
      chk("stall_id", bus.rf_id, 4);
      tick();
      chk("stall_cnt", bus.count, 1);
    end
    bus.is_stalling = 0;
    #1;
    chk("unstall_we", bus.rf_we, 1);
    tick();
    chk("unstall_cnt", bus.count, 0);
    wb(1, 1, 32'h11);
    mdu(1, 7, 32'h77);
    tick();
    wb(0, 0, 0);
    mdu(0, 0, 0);
    bus.is_stalling = 1;
    bus.rd_rt_id = 7;
    #1;
    chk("haz_rt", bus.hazard, 1);
    bus.rd_rt_id = 0;
    #1;
    chk("haz_none", bus.hazard, 0);
    bus.is_stalling = 0;
    tick();
    chk("haz_drain_cnt", bus.count, 0);
    mdu(1, 0, 32'h99);
    #1;
    chk("r0_haz", bus.hazard, 0);
    chk("r0_we", bus.rf_we, 0);
    tick();
    chk("r0_cnt", bus.count, 0);
    mdu(1, 12, 32'hCC);
    bus.rd_rs_id = 12;
    #1;
    chk("haz_mdu", bus.hazard, 1);
    tick();
    mdu(0, 0, 0);
    bus.rd_rs_id = 0;
    wb(1, 1, 32'h11);
    mdu(1, 10, 32'hA0);
    tick();
    mdu(1, 11, 32'hB0);
    tick();
    mdu(0, 0, 0);
    wb(0, 0, 0);
    chk("pre_rst_cnt", bus.count, 2);
    rst = 1;
    #1;
    chk("in_rst_we", bus.rf_we, 0);
    chk("in_rst_rdy", bus.mdu_ready, 0);
    tick();
    chk("post_rst_cnt", bus.count, 0);
    rst = 0;
    #1;
    chk("post_rst_rdy", bus.mdu_ready, 1);
    chk("post_rst_we", bus.rf_we, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
